instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, which sets the number of output FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 32, which sets the instruction-memory byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port enc_type, input, 3 bits: 0=OP, 1=OP-IMM, 2=LOAD, 3=STORE, 4=BRANCH; 5-7 are illegal.
REQ-008 SHALL have ports rd, rs1 and rs2, inputs, 5 bits each: register indices.
REQ-009 SHALL have port funct3, input, 3 bits.
REQ-010 SHALL have port funct7, input, 7 bits, used for OP only.
REQ-011 SHALL have port imm, input, 13 bits: signed immediate; bit 0 is ignored for BRANCH.
REQ-012 SHALL have port imem_we, output, 1 bit: instruction-memory write strobe.
REQ-013 SHALL have port imem_ready, input, 1 bit: the memory accepts a write this cycle.
REQ-014 SHALL have port imem_addr, output, ADDR_W bits: write byte address.
REQ-015 SHALL have port imem_wdata, output, 32 bits: the encoded instruction.
REQ-016 SHALL have port err, output, 1 bit: sticky illegal-request flag.
REQ-017 SHALL have port wr_count, output, 16 bits: count of words written to memory.

Function
REQ-018 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL equal 1 exactly when the FIFO is not full.
REQ-020 Opcodes SHALL be: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
REQ-021 OP SHALL encode {funct7,rs2,rs1,funct3,rd,op}.
REQ-022 OP-IMM and LOAD SHALL encode {imm[11:0],rs1,funct3,rd,op}.
REQ-023 STORE SHALL encode {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
REQ-024 BRANCH SHALL encode {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
REQ-025 An accepted legal request SHALL be pushed into the FIFO as one encoded word on the same edge.
REQ-026 imem_we SHALL equal 1 exactly when the FIFO is not empty.
REQ-027 imem_wdata SHALL present the FIFO head word.
REQ-028 The first word SHALL reach imem_we=1 one cycle after acceptance.
REQ-029 A word SHALL be popped on an edge where imem_we=1 and imem_ready=1; on that edge imem_addr SHALL advance by 4 and wr_count SHALL increment by 1.
REQ-030 While imem_ready=0, imem_we, imem_addr and imem_wdata SHALL hold stable.
REQ-031 imem_addr SHALL wrap modulo 2^ADDR_W, and wr_count SHALL wrap modulo 2^16.
REQ-032 When a push and a pop occur on the same edge while the FIFO is full, in_ready=0 blocks the push; the pop proceeds, and in_ready=1 on the next cycle.
REQ-033 When a push and a pop occur on the same edge at any other occupancy, occupancy SHALL be unchanged and FIFO order SHALL be preserved.
REQ-034 An illegal request (enc_type 5-7) SHALL be accepted but not pushed, and SHALL set err=1 on the next cycle.
REQ-035 err SHALL be cleared only by reset.
REQ-036 Words SHALL be written to memory strictly in acceptance order, with no loss or duplication.

Reset
REQ-037 While rst_n=0, asynchronously: FIFO empty, imem_we=0, imem_addr=0, imem_wdata=0, err=0, wr_count=0, in_ready=0.
REQ-038 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-039 Reset asserted mid-operation SHALL discard all queued words.

Configuration
REQ-040 With macro INSTR_ENCODER_RV32M_EN defined, an OP request with funct7=0000001 SHALL be encoded normally.
REQ-041 With INSTR_ENCODER_RV32M_EN undefined, an OP request with funct7=0000001 SHALL be treated as illegal, as in REQ-034.

Structure
REQ-042 A shared package SHALL hold the enc_type enumeration, the five opcode constants, and the funct7 constants 0000000, 0100000 and 0000001.
REQ-043 The FIFO SHALL be implemented as sub-module instr_fifo (parameters DEPTH and width 32, with push/pop/full/empty).
REQ-044 The encoding itself SHALL be combinational logic inside instr_encoder.

Verification
REQ-045 Test OP add: rd=3, rs1=1, rs2=2, f3=000, f7=0000000 -> imem_wdata=0x002081B3 at imem_addr=0x0, wr_count=1.
REQ-046 Test OP sub followed by RV32M mul, same registers, with INSTR_ENCODER_RV32M_EN defined -> 0x402081B3 at 0x0, then 0x022081B3 at 0x4. Repeat without the macro -> only the sub is written and err=1.
REQ-047 Test LOAD (rd=5, rs1=2, imm=8, f3=010) followed by STORE (rs2=5, rs1=2, imm=12, f3=010) -> 0x00812283, then 0x00512623.
REQ-048 Test BRANCH beq: rs1=1, rs2=2, imm=-4 -> 0xFE208EE3.
REQ-049 Test backpressure: hold imem_ready=0 and issue 5 requests -> in_ready=0 after 4 accepted, outputs held stable; then set imem_ready=1 -> 4 writes at consecutive addresses, the 5th request is accepted, and order is preserved.
REQ-050 Test reset mid-operation: pulse rst_n low with 3 words queued -> outputs take reset values immediately, and the next write goes to imem_addr=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32 instruction encoder: request types, opcodes,
// funct7 constants and the encoder result record.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    ENC_OP     = 3'd0,
    ENC_OP_IMM = 3'd1,
    ENC_LOAD   = 3'd2,
    ENC_STORE  = 3'd3,
    ENC_BRANCH = 3'd4
  } enc_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic                 legal;
    logic [INSTR_W-1:0]   word;
  } enc_result_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words awaiting the memory write.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; reset only clears the pointers,
  // and the consumer masks the head word while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

  assign dout = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Encodes RV32 OP/OP-IMM/LOAD/STORE/BRANCH requests and streams the words to
// instruction memory in order. Define INSTR_ENCODER_RV32M_EN to allow MUL/DIV.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        enc_type,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [12:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  enc_result_t        enc;
  logic               run;
  logic               accept;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] fifo_head;

  // NOTE: every field of enc gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    enc.legal = 1'b1;
    enc.word  = '0;
    case (enc_type)
      ENC_OP: begin
        enc.word = {funct7, rs2, rs1, funct3, rd, OPC_OP};
`ifdef INSTR_ENCODER_RV32M_EN
        enc.legal = 1'b1;
`else
        if (funct7 == F7_MULDIV) enc.legal = 1'b0;
`endif
      end
      ENC_OP_IMM: enc.word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      ENC_LOAD:   enc.word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      ENC_STORE:  enc.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      ENC_BRANCH: enc.word = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], OPC_BRANCH};
      default:    enc.legal = 1'b0;
    endcase
  end

  // run holds in_ready low until the first edge after reset release.
  assign in_ready = run && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc.legal;
  assign imem_we  = !fifo_empty;
  assign pop      = imem_we && imem_ready;

  assign imem_wdata = fifo_empty ? '0 : fifo_head;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (enc.word),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      err       <= 1'b0;
      imem_addr <= '0;
      wr_count  <= '0;
    end else begin
      run <= 1'b1;
      if (accept && !enc.legal) err <= 1'b1;
      if (pop) begin
        imem_addr <= imem_addr + ADDR_STEP;
        wr_count  <= wr_count + 16'd1;
      end
    end
  end

endmodule
